// File: rtl/bat_amateur_loader.sv
`timescale 1ns/1ps
// Program loader: receives a length-prefixed word image over a byte link into local RAM,
// holding the CPU in reset until the image is complete, then serves CPU reads/writes.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// ST_WAIT   | idle or aborted load, CPU held in reset, waits for LOAD_START
// ST_LEN_HI | expecting high byte of word count
// ST_LEN_LO | expecting low byte of word count, decides run/abort/body
// ST_BODY_HI| expecting upper byte of next program word
// ST_BODY_LO| expecting lower byte, writes the word to RAM
// ST_RUN    | CPU released, RAM serves CPU accesses
module bat_amateur_loader #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int MEM_AW        = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [7:0]               RX_DATA,
    input  logic                     RX_VALID,
    output logic                     RX_READY,
    input  logic                     LOAD_START,
    inout  wire  [15:0]              DATA,
    input  logic [ADDRESS_WIDTH-1:0] ADDRESS,
    input  logic                     RAM_RW,
    input  logic                     RAM_EN,
    output logic                     CPU_RST,
    output logic                     LOAD_BUSY,
    output logic                     LOAD_ERR
);

    localparam int          DEPTH   = 2 ** MEM_AW;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_BODY_HI,
        ST_BODY_LO,
        ST_RUN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_len_hi;
    logic [15:0]         r_len;
    logic [7:0]          r_upper;
    logic [MEM_AW:0]     r_ptr;
    logic                r_load_err;
    logic [15:0]         r_mem [0:DEPTH-1];

    logic                w_accept;
    logic                w_load_go;
    logic                w_err_set;
    logic [15:0]         w_len_rx;
    logic [MEM_AW:0]     w_ptr_inc;
    logic                w_addr_ok;
    logic                w_cpu_rd;
    logic                w_cpu_wr;
    logic                w_load_wr;
    logic [15:0]         w_rd_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load_go   = 1'b0;
        w_err_set   = 1'b0;
        RX_READY    = 1'b0;
        LOAD_BUSY   = 1'b0;
        CPU_RST     = 1'b1;
        w_len_rx    = {r_len_hi, RX_DATA};
        w_ptr_inc   = r_ptr + 1'b1;
        case (r_state)
            ST_WAIT: begin
                if (LOAD_START) begin
                    w_load_go   = 1'b1;
                    w_state_nxt = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                RX_READY  = 1'b1;
                LOAD_BUSY = 1'b1;
                if (RX_VALID) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                RX_READY  = 1'b1;
                LOAD_BUSY = 1'b1;
                if (RX_VALID) begin
                    w_accept = 1'b1;
                    if (w_len_rx == 16'h0000) begin
                        w_state_nxt = ST_RUN;
                    end else if ({1'b0, w_len_rx} > DEPTH_W) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_BODY_HI;
                    end
                end
            end
            ST_BODY_HI: begin
                RX_READY  = 1'b1;
                LOAD_BUSY = 1'b1;
                if (RX_VALID) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BODY_LO;
                end
            end
            ST_BODY_LO: begin
                RX_READY  = 1'b1;
                LOAD_BUSY = 1'b1;
                if (RX_VALID) begin
                    w_accept = 1'b1;
                    if (16'(w_ptr_inc) == r_len) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_BODY_HI;
                    end
                end
            end
            ST_RUN: begin
                CPU_RST = 1'b0;
                if (LOAD_START) begin
                    w_load_go   = 1'b1;
                    w_state_nxt = ST_LEN_HI;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_len_hi   <= 8'h00;
            r_len      <= 16'h0000;
            r_upper    <= 8'h00;
            r_ptr      <= '0;
            r_load_err <= 1'b0;
        end else begin
            if (w_load_go) begin
                r_load_err <= 1'b0;
                r_ptr      <= '0;
            end
            if (w_accept) begin
                case (r_state)
                    ST_LEN_HI:  r_len_hi <= RX_DATA;
                    ST_LEN_LO: begin
                        r_len <= w_len_rx;
                        if (w_err_set) begin
                            r_load_err <= 1'b1;
                        end
                    end
                    ST_BODY_HI: r_upper  <= RX_DATA;
                    ST_BODY_LO: r_ptr    <= w_ptr_inc;
                    default: ;
                endcase
            end
        end
    end

    assign LOAD_ERR  = r_load_err;

    // Addresses with any bit set above the RAM index are out of range, never aliased.
    assign w_addr_ok = ((ADDRESS >> MEM_AW) == '0);
    assign w_cpu_rd  = (r_state == ST_RUN) && RAM_EN && RAM_RW;
    assign w_cpu_wr  = (r_state == ST_RUN) && RAM_EN && !RAM_RW && w_addr_ok;
    assign w_load_wr = w_accept && (r_state == ST_BODY_LO);
    assign w_rd_data = w_addr_ok ? r_mem[ADDRESS[MEM_AW-1:0]] : 16'h0000;
    assign DATA      = w_cpu_rd ? w_rd_data : 16'hzzzz;

    // No reset on the RAM so a program survives RST and aborted loads.
    always_ff @(posedge CLK) begin
        if (w_load_wr) begin
            r_mem[r_ptr[MEM_AW-1:0]] <= {r_upper, RX_DATA};
        end
        if (w_cpu_wr) begin
            r_mem[ADDRESS[MEM_AW-1:0]] <= DATA;
        end
    end

endmodule

// File: tb/tb_bat_amateur_loader.sv
`timescale 1ns/1ps
// Directed bench for bat_amateur_loader: RAM model plus a queue of expected read data,
// checked with immediate assertions.
module tb_bat_amateur_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        LOAD_START;
    wire  [15:0] DATA;
    logic [15:0] ADDRESS;
    logic        RAM_RW;
    logic        RAM_EN;
    logic        CPU_RST;
    logic        LOAD_BUSY;
    logic        LOAD_ERR;

    logic        drv_en;
    logic [15:0] r_drv;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_mem [0:255];
    logic [15:0] sb_q [$];

    assign DATA = drv_en ? r_drv : 16'hzzzz;

    always #5 CLK = ~CLK;

    bat_amateur_loader #(.ADDRESS_WIDTH(16), .MEM_AW(8)) dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(RX_READY), .LOAD_START(LOAD_START), .DATA(DATA),
        .ADDRESS(ADDRESS), .RAM_RW(RAM_RW), .RAM_EN(RAM_EN),
        .CPU_RST(CPU_RST), .LOAD_BUSY(LOAD_BUSY), .LOAD_ERR(LOAD_ERR)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        logic ok;
        ok       = 1'b0;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (RX_READY) ok = 1'b1;
            tick();
        end
        RX_VALID = 1'b0;
        chk("rx_accept", {15'd0, ok}, 16'd1);
        if (gap) tick();
    endtask

    task automatic start_load();
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0;
    endtask

    // Sends length then n words (seed + i*0x0101), updating the RAM model.
    task automatic load_words(input int n, input bit gap, input logic [15:0] seed);
        logic [15:0] w;
        send_byte(8'(n >> 8), gap);
        send_byte(8'(n), gap);
        for (int i = 0; i < n; i++) begin
            w = seed + 16'(i * 16'h0101);
            exp_mem[i] = w;
            send_byte(w[15:8], gap);
            if (i == n - 1) chk("cpu_rst_before_last", {15'd0, CPU_RST}, 16'd1);
            send_byte(w[7:0], gap);
        end
        chk("cpu_rst_after_load", {15'd0, CPU_RST}, 16'd0);
        chk("busy_after_load", {15'd0, LOAD_BUSY}, 16'd0);
    endtask

    task automatic cpu_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        logic [15:0] e;
        drv_en  = 1'b0;
        ADDRESS = addr;
        RAM_RW  = 1'b1;
        RAM_EN  = 1'b1;
        sb_q.push_back(exp);
        #1;
        e = sb_q.pop_front();
        chk(tag, DATA, e);
        RAM_EN  = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [15:0] d);
        drv_en  = 1'b1;
        r_drv   = d;
        ADDRESS = addr;
        RAM_RW  = 1'b0;
        RAM_EN  = 1'b1;
        tick();
        RAM_EN  = 1'b0;
        RAM_RW  = 1'b1;
        drv_en  = 1'b0;
        if (addr < 16'd256) exp_mem[addr[7:0]] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; RX_DATA = 8'h00; RX_VALID = 1'b0; LOAD_START = 1'b0;
        ADDRESS = 16'h0000; RAM_RW = 1'b1; RAM_EN = 1'b0; drv_en = 1'b0; r_drv = 16'h0000;
        tick(); tick();
        chk("rst_cpu_rst", {15'd0, CPU_RST}, 16'd1);
        chk("rst_rx_ready", {15'd0, RX_READY}, 16'd0);
        chk("rst_busy", {15'd0, LOAD_BUSY}, 16'd0);
        chk("rst_err", {15'd0, LOAD_ERR}, 16'd0);
        RST = 1'b0;
        tick();
        chk("wait_rx_ready", {15'd0, RX_READY}, 16'd0);

        // Full-depth image: 256 words is the largest legal length.
        start_load();
        chk("busy_in_load", {15'd0, LOAD_BUSY}, 16'd1);
        chk("ready_in_load", {15'd0, RX_READY}, 16'd1);
        load_words(256, 1'b0, 16'h1000);
        cpu_read("full_w0", 16'h0000, exp_mem[0]);
        cpu_read("full_w128", 16'h0080, exp_mem[128]);
        cpu_read("full_w255", 16'h00FF, exp_mem[255]);

        // Basic load 00 02 12 34 AB CD.
        chk("run_rx_ready", {15'd0, RX_READY}, 16'd0);
        start_load();
        send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'hAB, 1'b0);
        chk("basic_cpu_rst_pre", {15'd0, CPU_RST}, 16'd1);
        send_byte(8'hCD, 1'b0);
        chk("basic_cpu_rst_post", {15'd0, CPU_RST}, 16'd0);
        exp_mem[0] = 16'h1234; exp_mem[1] = 16'hABCD;
        cpu_read("basic_w1", 16'h0001, 16'hABCD);
        cpu_read("basic_w0", 16'h0000, 16'h1234);
        cpu_read("beyond_n_kept", 16'h0002, exp_mem[2]);

        // Same kind of load with RX_VALID toggling every cycle.
        start_load();
        load_words(3, 1'b1, 16'h4C21);
        chk("gap_run_rx_ready", {15'd0, RX_READY}, 16'd0);
        cpu_read("gap_w0", 16'h0000, exp_mem[0]);
        cpu_read("gap_w1", 16'h0001, exp_mem[1]);
        cpu_read("gap_w2", 16'h0002, exp_mem[2]);

        // Length 257 overflows.
        start_load();
        send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
        chk("ovf_err", {15'd0, LOAD_ERR}, 16'd1);
        chk("ovf_cpu_rst", {15'd0, CPU_RST}, 16'd1);
        chk("ovf_busy", {15'd0, LOAD_BUSY}, 16'd0);
        chk("ovf_rx_ready", {15'd0, RX_READY}, 16'd0);
        start_load();
        chk("err_cleared", {15'd0, LOAD_ERR}, 16'd0);
        load_words(1, 1'b0, 16'hBEEF);
        cpu_read("after_ovf_w0", 16'h0000, 16'hBEEF);
        cpu_read("after_ovf_w1", 16'h0001, exp_mem[1]);
        cpu_read("after_ovf_w3", 16'h0003, exp_mem[3]);

        // CPU writes in and out of range.
        cpu_write(16'h0010, 16'h5A5A);
        cpu_read("cpu_wr_rd", 16'h0010, 16'h5A5A);
        cpu_write(16'h0100, 16'h1234);
        cpu_read("oor_read", 16'h0100, 16'h0000);
        cpu_read("oor_no_alias", 16'h0000, exp_mem[0]);

        // CPU write on the same edge as LOAD_START, then a zero-length load.
        drv_en = 1'b1; r_drv = 16'hC3C3; ADDRESS = 16'h0020; RAM_RW = 1'b0; RAM_EN = 1'b1;
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0; RAM_EN = 1'b0; RAM_RW = 1'b1; drv_en = 1'b0;
        exp_mem[32] = 16'hC3C3;
        chk("wr_start_busy", {15'd0, LOAD_BUSY}, 16'd1);
        send_byte(8'h00, 1'b0);
        chk("zero_len_cpu_rst_pre", {15'd0, CPU_RST}, 16'd1);
        send_byte(8'h00, 1'b0);
        chk("zero_len_cpu_rst", {15'd0, CPU_RST}, 16'd0);
        cpu_read("wr_start_data", 16'h0020, 16'hC3C3);
        cpu_read("zero_len_keep", 16'h0010, 16'h5A5A);

        // Reset after 3 of 6 body bytes.
        start_load();
        send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
        send_byte(8'h77, 1'b0); send_byte(8'h88, 1'b0); send_byte(8'h99, 1'b0);
        exp_mem[0] = 16'h7788;
        #2;
        RST = 1'b1;
        #1;
        chk("midrst_cpu_rst", {15'd0, CPU_RST}, 16'd1);
        chk("midrst_busy", {15'd0, LOAD_BUSY}, 16'd0);
        chk("midrst_rx_ready", {15'd0, RX_READY}, 16'd0);
        chk("midrst_err", {15'd0, LOAD_ERR}, 16'd0);
        tick();
        RST = 1'b0;
        RX_VALID = 1'b1; RX_DATA = 8'h00;
        tick(); tick();
        chk("post_rst_wait", {15'd0, RX_READY}, 16'd0);
        chk("post_rst_cpu_rst", {15'd0, CPU_RST}, 16'd1);
        RX_VALID = 1'b0;
        start_load();
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        cpu_read("post_rst_w0", 16'h0000, 16'h7788);
        cpu_read("post_rst_w1", 16'h0001, exp_mem[1]);
        cpu_read("post_rst_w10", 16'h0010, 16'h5A5A);
        cpu_read("post_rst_w255", 16'h00FF, exp_mem[255]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
